// File: rtl/lmfc_if.sv
// SYSREF input, LMFC configuration and LMFC/alignment status of the lmfc_tracker.
// The tracker connects through the slave modport; the driving side uses the master modport.
interface lmfc_if #(
    parameter int CNT_WIDTH      = 8,
    parameter int EDGE_CNT_WIDTH = 8
);
    logic                      sysref_i;
    logic [1:0]                cfg_mode_i;
    logic [CNT_WIDTH-1:0]      cfg_beats_i;
    logic [CNT_WIDTH-1:0]      cfg_offset_i;
    logic                      cfg_rearm_i;
    logic                      err_clear_i;
    logic                      lmfc_pulse_o;
    logic [CNT_WIDTH-1:0]      lmfc_counter_o;
    logic                      lmfc_valid_o;
    logic                      sysref_aligned_o;
    logic                      sysref_err_o;
    logic [CNT_WIDTH-1:0]      sysref_err_phase_o;
    logic                      cfg_err_o;
    logic [EDGE_CNT_WIDTH-1:0] sysref_cnt_o;

    modport master (
        output sysref_i, cfg_mode_i, cfg_beats_i, cfg_offset_i, cfg_rearm_i, err_clear_i,
        input  lmfc_pulse_o, lmfc_counter_o, lmfc_valid_o, sysref_aligned_o,
               sysref_err_o, sysref_err_phase_o, cfg_err_o, sysref_cnt_o
    );

    modport slave (
        input  sysref_i, cfg_mode_i, cfg_beats_i, cfg_offset_i, cfg_rearm_i, err_clear_i,
        output lmfc_pulse_o, lmfc_counter_o, lmfc_valid_o, sysref_aligned_o,
               sysref_err_o, sysref_err_phase_o, cfg_err_o, sysref_cnt_o
    );
endinterface

// File: rtl/lmfc_tracker.sv
// Local multiframe clock generator: synchronises SYSREF, aligns the LMFC counter to it
// with a programmable offset, checks every SYSREF edge against the running phase.
module lmfc_tracker #(
    parameter int CNT_WIDTH      = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int EDGE_CNT_WIDTH = 8
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    lmfc_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0]      CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]      CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [EDGE_CNT_WIDTH-1:0] EDGE_ZERO = {EDGE_CNT_WIDTH{1'b0}};
    localparam logic [EDGE_CNT_WIDTH-1:0] EDGE_ONE  = {{(EDGE_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [EDGE_CNT_WIDTH-1:0] EDGE_MAX  = {EDGE_CNT_WIDTH{1'b1}};

    logic [SYNC_STAGES-1:0]    sync_q, sync_d;
    logic                      hist_q, hist_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic                      valid_q, valid_d;
    logic                      armed_q, armed_d;
    logic                      aligned_q, aligned_d;
    logic                      err_q, err_d;
    logic [CNT_WIDTH-1:0]      phase_q, phase_d;
    logic                      cfg_err_q, cfg_err_d;
    logic [EDGE_CNT_WIDTH-1:0] ecnt_q, ecnt_d;
    logic                      pulse_q, pulse_d;

    logic                      edge_s, oneshot_s, cont_s, active_edge_s;
    logic                      armed_eff_s, do_load_s, do_check_s, offset_bad_s;
    logic [CNT_WIDTH-1:0]      term_s, next_cnt_s, load_val_s;

    // Mode decode; the reserved encoding behaves like off.
    always_comb begin
        oneshot_s = 1'b0;
        cont_s    = 1'b0;
        case (bus.cfg_mode_i)
            2'b01:   oneshot_s = 1'b1;
            2'b10:   cont_s    = 1'b1;
            default: begin
                oneshot_s = 1'b0;
                cont_s    = 1'b0;
            end
        endcase
    end

    // Next-state logic for synchroniser, counter, alignment and status.
    always_comb begin
        sync_d        = {sync_q[SYNC_STAGES-2:0], bus.sysref_i};
        hist_d        = sync_q[SYNC_STAGES-1];
        edge_s        = sync_q[SYNC_STAGES-1] & ~hist_q;
        active_edge_s = edge_s & (oneshot_s | cont_s);

        // beats==0 wraps the terminal value to all-ones, i.e. a full 2^CNT_WIDTH multiframe.
        term_s       = bus.cfg_beats_i - CNT_ONE;
        next_cnt_s   = (cnt_q == term_s) ? CNT_ZERO : cnt_q + CNT_ONE;
        offset_bad_s = (bus.cfg_beats_i != CNT_ZERO) && (bus.cfg_offset_i > term_s);
        load_val_s   = offset_bad_s ? CNT_ZERO : bus.cfg_offset_i;

        // A rearm landing on the same cycle as an edge still counts as armed for that edge.
        armed_eff_s = armed_q | bus.cfg_rearm_i;
        do_load_s   = edge_s & ((oneshot_s & armed_eff_s) | cont_s);
        do_check_s  = edge_s & valid_q & ((oneshot_s & ~armed_eff_s) | cont_s);

        cnt_d     = next_cnt_s;
        valid_d   = valid_q;
        armed_d   = armed_eff_s;
        aligned_d = aligned_q;
        err_d     = bus.err_clear_i ? 1'b0 : err_q;
        phase_d   = bus.err_clear_i ? CNT_ZERO : phase_q;
        cfg_err_d = bus.err_clear_i ? 1'b0 : cfg_err_q;
        pulse_d   = (cnt_q == CNT_ZERO) & valid_q;

        if (do_check_s) begin
            if (next_cnt_s == load_val_s) begin
                aligned_d = 1'b1;
            end else begin
                aligned_d = 1'b0;
                err_d     = 1'b1;
                phase_d   = next_cnt_s;
            end
        end else begin
            aligned_d = aligned_q;
        end

        if (do_load_s) begin
            cnt_d   = load_val_s;
            valid_d = 1'b1;
            if (oneshot_s) begin
                armed_d = 1'b0;
            end else begin
                armed_d = armed_eff_s;
            end
            if (!do_check_s) begin
                aligned_d = 1'b1;
            end else begin
                aligned_d = aligned_d;
            end
            if (offset_bad_s) begin
                cfg_err_d = 1'b1;
            end else begin
                cfg_err_d = cfg_err_d;
            end
        end else begin
            cnt_d = next_cnt_s;
        end

        if (active_edge_s) begin
            if (bus.err_clear_i) begin
                ecnt_d = EDGE_ONE;
            end else if (ecnt_q != EDGE_MAX) begin
                ecnt_d = ecnt_q + EDGE_ONE;
            end else begin
                ecnt_d = EDGE_MAX;
            end
        end else if (bus.err_clear_i) begin
            ecnt_d = EDGE_ZERO;
        end else begin
            ecnt_d = ecnt_q;
        end
    end

    // State registers; reset leaves the tracker armed for its first one-shot alignment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= {SYNC_STAGES{1'b0}};
            hist_q    <= 1'b0;
            cnt_q     <= CNT_ZERO;
            valid_q   <= 1'b0;
            armed_q   <= 1'b1;
            aligned_q <= 1'b0;
            err_q     <= 1'b0;
            phase_q   <= CNT_ZERO;
            cfg_err_q <= 1'b0;
            ecnt_q    <= EDGE_ZERO;
            pulse_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            armed_q   <= armed_d;
            aligned_q <= aligned_d;
            err_q     <= err_d;
            phase_q   <= phase_d;
            cfg_err_q <= cfg_err_d;
            ecnt_q    <= ecnt_d;
            pulse_q   <= pulse_d;
        end
    end

    assign bus.lmfc_pulse_o       = pulse_q;
    assign bus.lmfc_counter_o     = cnt_q;
    assign bus.lmfc_valid_o       = valid_q;
    assign bus.sysref_aligned_o   = aligned_q;
    assign bus.sysref_err_o       = err_q;
    assign bus.sysref_err_phase_o = phase_q;
    assign bus.cfg_err_o          = cfg_err_q;
    assign bus.sysref_cnt_o       = ecnt_q;
endmodule

// File: tb/tb_lmfc_tracker.sv
// Bench for lmfc_tracker: table of whole scenarios with hand-derived end states,
// plus hand-written sequences for rearm, error clear, config shrink, saturation and async reset.
module tb_lmfc_tracker;
    localparam int CW = 8;
    localparam int SS = 2;
    localparam int EW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lmfc_if #(.CNT_WIDTH(CW), .EDGE_CNT_WIDTH(EW)) bus ();

    lmfc_tracker #(.CNT_WIDTH(CW), .SYNC_STAGES(SS), .EDGE_CNT_WIDTH(EW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] cnt;
        logic       valid;
        logic       aligned;
        logic       err;
        logic [7:0] phase;
        logic       cfg_err;
        logic [7:0] ecnt;
        logic       pulse;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] beats;
        logic [7:0] offset;
        int         e0, e1, e2;
        int         n;
        exp_t       exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[10];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    function automatic exp_t mk(input string nm, input logic [7:0] c, input logic v,
                                input logic a, input logic e, input logic [7:0] ph,
                                input logic ce, input logic [7:0] ec, input logic p);
        exp_t r;
        r.name = nm; r.cnt = c; r.valid = v; r.aligned = a; r.err = e;
        r.phase = ph; r.cfg_err = ce; r.ecnt = ec; r.pulse = p;
        return r;
    endfunction

    function automatic vec_t mkv(input logic [1:0] m, input logic [7:0] b, input logic [7:0] o,
                                 input int a0, input int a1, input int a2, input int n,
                                 input exp_t e);
        vec_t r;
        r.mode = m; r.beats = b; r.offset = o;
        r.e0 = a0; r.e1 = a1; r.e2 = a2; r.n = n; r.exp = e;
        return r;
    endfunction

    function automatic logic in_win(input int c, input int e);
        return (e > 0) && (c >= e) && (c <= e + 1);
    endfunction

    task automatic chk(input string nm, input string field, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: actual=%0d expected=%0d", nm, field, act, exp);
        end
    endtask

    task automatic check_out(input exp_t e);
        chk(e.name, "counter", bus.lmfc_counter_o, e.cnt);
        chk(e.name, "valid", bus.lmfc_valid_o, e.valid);
        chk(e.name, "aligned", bus.sysref_aligned_o, e.aligned);
        chk(e.name, "err", bus.sysref_err_o, e.err);
        chk(e.name, "err_phase", bus.sysref_err_phase_o, e.phase);
        chk(e.name, "cfg_err", bus.cfg_err_o, e.cfg_err);
        chk(e.name, "sysref_cnt", bus.sysref_cnt_o, e.ecnt);
        chk(e.name, "pulse", bus.lmfc_pulse_o, e.pulse);
    endtask

    task automatic pop_check();
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard: actual=empty expected=entry");
        end else begin
            check_out(sb_q.pop_front());
        end
    endtask

    // After tick the bench sits at the falling edge following rising edge number cyc.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until(input int c);
        while (cyc < c) tick();
    endtask

    // SYSREF high for rising edges c and c+1.
    task automatic pulse_sysref_at(input int c);
        run_until(c - 1);
        bus.sysref_i = 1'b1;
        tick();
        tick();
        bus.sysref_i = 1'b0;
    endtask

    task automatic do_reset(input logic [1:0] m, input logic [7:0] b, input logic [7:0] o);
        rst_n            = 1'b0;
        bus.sysref_i     = 1'b0;
        bus.cfg_rearm_i  = 1'b0;
        bus.err_clear_i  = 1'b0;
        bus.cfg_mode_i   = m;
        bus.cfg_beats_i  = b;
        bus.cfg_offset_i = o;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic run_vec(input vec_t v);
        do_reset(v.mode, v.beats, v.offset);
        sb_q.push_back(v.exp);
        for (int c = 1; c <= v.n; c++) begin
            bus.sysref_i = in_win(c, v.e0) | in_win(c, v.e1) | in_win(c, v.e2);
            tick();
        end
        bus.sysref_i = 1'b0;
        pop_check();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // SYSREF sampled at edge e loads the counter at edge e+2.
        vecs[0] = mkv(2'b00, 8'd4, 8'd0, 0, 0, 0, 0, mk("reset_state", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0));
        vecs[1] = mkv(2'b01, 8'd4, 8'd0, 3, 0, 0, 14, mk("oneshot_single", 8'd1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd1, 1'b1));
        vecs[2] = mkv(2'b01, 8'd4, 8'd0, 3, 11, 19, 22, mk("periodic_aligned", 8'd1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd3, 1'b1));
        vecs[3] = mkv(2'b01, 8'd4, 8'd0, 3, 12, 0, 16, mk("oneshot_shift", 8'd3, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 8'd2, 1'b0));
        vecs[4] = mkv(2'b10, 8'd4, 8'd2, 3, 12, 0, 21, mk("cont_shift", 8'd1, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 8'd2, 1'b1));
        vecs[5] = mkv(2'b01, 8'd4, 8'd5, 3, 0, 0, 9, mk("offset_too_big", 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1, 8'd1, 1'b0));
        vecs[6] = mkv(2'b01, 8'd0, 8'd250, 3, 0, 0, 12, mk("beats_zero_wrap", 8'd1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd1, 1'b1));
        vecs[7] = mkv(2'b00, 8'd4, 8'd0, 3, 11, 0, 14, mk("mode_off", 8'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0));
        vecs[8] = mkv(2'b11, 8'd4, 8'd0, 3, 11, 0, 14, mk("mode_reserved", 8'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0));
        vecs[9] = mkv(2'b10, 8'd4, 8'd1, 3, 11, 0, 15, mk("cont_aligned", 8'd3, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd2, 1'b0));

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Misaligned one-shot edge, then rearm: next edge reloads, sticky error remains.
        do_reset(2'b01, 8'd4, 8'd0);
        pulse_sysref_at(3);
        pulse_sysref_at(12);
        run_until(16);
        bus.cfg_rearm_i = 1'b1;
        tick();
        bus.cfg_rearm_i = 1'b0;
        pulse_sysref_at(20);
        sb_q.push_back(mk("rearm_realign", 8'd0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 8'd3, 1'b1));
        tick();
        pop_check();

        // Continuous: plain clear, then clear coincident with a new misaligned edge.
        do_reset(2'b10, 8'd4, 8'd2);
        pulse_sysref_at(3);
        pulse_sysref_at(12);
        run_until(15);
        bus.err_clear_i = 1'b1;
        sb_q.push_back(mk("err_clear", 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0));
        tick();
        bus.err_clear_i = 1'b0;
        pop_check();
        pulse_sysref_at(21);
        bus.err_clear_i = 1'b1;
        sb_q.push_back(mk("clear_vs_new_err", 8'd2, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 8'd1, 1'b0));
        tick();
        bus.err_clear_i = 1'b0;
        pop_check();

        // Rearm on the same cycle as an edge realigns; the flag ends disarmed.
        do_reset(2'b01, 8'd4, 8'd0);
        pulse_sysref_at(3);
        pulse_sysref_at(10);
        bus.cfg_rearm_i = 1'b1;
        sb_q.push_back(mk("rearm_with_edge", 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd2, 1'b0));
        tick();
        bus.cfg_rearm_i = 1'b0;
        pop_check();
        pulse_sysref_at(17);
        sb_q.push_back(mk("disarmed_after", 8'd3, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 8'd3, 1'b0));
        tick();
        pop_check();

        // Shrinking beats below the counter runs on to the natural 8-bit wrap.
        do_reset(2'b00, 8'd8, 8'd0);
        run_until(6);
        bus.cfg_beats_i = 8'd4;
        run_until(255);
        sb_q.push_back(mk("shrink_at_255", 8'd255, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0));
        pop_check();
        tick();
        sb_q.push_back(mk("shrink_wrap", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0));
        pop_check();
        run_until(260);
        sb_q.push_back(mk("shrink_new_term", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0));
        pop_check();

        // 260 aligned edges every 8 cycles: edge count saturates at 255.
        do_reset(2'b10, 8'd4, 8'd0);
        for (int j = 0; j < 260; j++) pulse_sysref_at(3 + 8 * j);
        sb_q.push_back(mk("edge_cnt_sat", 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd255, 1'b0));
        tick();
        pop_check();

        // Asynchronous reset mid-multiframe clears outputs without a clock edge.
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        sb_q.push_back(mk("async_reset", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0));
        #1;
        pop_check();
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/lmfc_tracker.md
# lmfc_tracker

Parametrised Local Multi-Frame Clock generator for the JESD204B receive path, the successor to the fixed-size LMFC counter. Synchronises SYSREF, aligns a runtime-configurable multiframe counter to it with a programmable phase offset, and supports one-shot (re-armable) or continuous alignment. Every SYSREF edge is checked against the running LMFC phase; misalignment is flagged and logged for link bring-up and deterministic-latency debug. Sits between the SYSREF input pin and the lane deskew and ILA logic that consumes the LMFC pulse and counter.

## Interface
- CNT_WIDTH, 8, width of the LMFC counter, offset and beats configuration
- SYNC_STAGES, 2, SYSREF synchroniser depth (>=2)
- EDGE_CNT_WIDTH, 8, width of the saturating SYSREF edge counter
- clk_i  in  1  device/core clock
- rst_ni  in  1  reset; asynchronous, active-low
- sysref_i  in  1  raw SYSREF (asynchronous)
- cfg_mode_i  in  2  00 off, 01 one-shot, 10 continuous, 11 reserved (treated as 00)
- cfg_beats_i  in  CNT_WIDTH  beats per multiframe; 0 means 2^CNT_WIDTH
- cfg_offset_i  in  CNT_WIDTH  counter value loaded on alignment
- cfg_rearm_i  in  1  one-cycle pulse, re-arms one-shot alignment
- err_clear_i  in  1  one-cycle pulse, clears sticky error, phase capture and edge count
- lmfc_pulse_o  out  1  one-cycle LMFC boundary pulse
- lmfc_counter_o  out  CNT_WIDTH  current beat within multiframe
- lmfc_valid_o  out  1  counter has been aligned at least once since reset
- sysref_aligned_o  out  1  last checked edge matched expected phase
- sysref_err_o  out  1  sticky misalignment flag
- sysref_err_phase_o  out  CNT_WIDTH  expected-next counter value at the most recent misaligned edge
- cfg_err_o  out  1  sticky: offset >= beats seen at an alignment
- sysref_cnt_o  out  EDGE_CNT_WIDTH  saturating count of SYSREF edges

## Operation
- Sync: sysref_i through SYNC_STAGES flops, then one history flop; edge event E = synced 1 and history 0.
- Terminal value T = (cfg_beats_i - 1) mod 2^CNT_WIDTH. Free run: counter = 0 after T, else +1. Counter runs from reset in all modes.
- next_cnt = value the counter would take this cycle without alignment. load_val = cfg_offset_i, or 0 with cfg_err_o set if cfg_offset_i > T (unless beats==0).
- Mode off/reserved: E ignored entirely (no count, no check, no load).
- One-shot: armed flag set by reset and by cfg_rearm_i. E while armed: counter <= load_val, lmfc_valid_o <= 1, armed <= 0, sysref_aligned_o <= 1. E while not armed: check only.
- Continuous: every E loads load_val and sets valid; check performed first if already valid.
- Check (valid=1 at E): aligned iff next_cnt == load_val. Aligned: sysref_aligned_o <= 1. Misaligned: sysref_aligned_o <= 0, sysref_err_o <= 1, sysref_err_phase_o <= next_cnt.
- sysref_cnt_o increments on each E in modes 01/10, saturates at all-ones.
- err_clear_i clears sysref_err_o, sysref_err_phase_o, cfg_err_o, sysref_cnt_o. Same-cycle new error or E: set/increment wins (count becomes 1).
- cfg_rearm_i coincident with E in one-shot: E realigns, armed ends 0.
- Config changes take effect the cycle they are sampled; shrinking beats below current counter: counter continues incrementing until wrapping at 2^CNT_WIDTH-1 -> 0 (no forced reset).

## Timing
- Reset (async assert, sync behaviour on release): counter 0, all outputs 0, armed 1.
- sysref_i rising sampled at edge n -> E in cycle n+SYNC_STAGES; load visible on lmfc_counter_o in next cycle.
- lmfc_pulse_o registered: high the cycle after lmfc_counter_o == 0 while lmfc_valid_o == 1; period = beats cycles once aligned.
- Flags/phase capture update the cycle after E. SYSREF held high: single E.

## Test plan
- One-shot, beats=4, offset=0, single SYSREF: counter 0 one cycle after E, pulse every 4 cycles, valid=1, sysref_cnt=1, err=0.
- Periodic SYSREF every 8 cycles, beats=4, offset=0: all edges aligned, err=0, sysref_cnt increments per edge, saturates at 255.
- One-shot, SYSREF phase shifted by 1: err=1, err_phase=1, counter not reloaded; rearm then next edge realigns, counter = offset.
- Continuous, shifted edge: err=1, counter reloaded to offset=2, following pulses track new phase; err_clear coincident with new error leaves err=1.
- offset=5, beats=4: counter loads 0, cfg_err=1; beats=0: counter wraps 255 -> 0.
- Mode 00: edges produce no count/valid; async reset mid-multiframe zeroes all outputs immediately.
